// File: rtl/pacman_pkg.sv
// Shared types and screen geometry for the Pacman motion controller and the VGA pixel mux.
package pacman_pkg;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int SPRITE_PX  = 22;
  localparam int START_X_PX = 310;
  localparam int START_Y_PX = 230;
  localparam int MAP_ADDR_W = 20;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PROBE_A  = 3'd1,
    PROBE_B  = 3'd2,
    CAPTURE  = 3'd3,
    DECIDE   = 3'd4,
    STEP     = 3'd5
  } mc_state_t;

  // Button priority when several are held: up > down > left > right.
  function automatic dir_t btn_priority(input logic up, input logic down,
                                        input logic left);
    dir_t d;
    if (up)        d = UP;
    else if (down) d = DOWN;
    else if (left) d = LEFT;
    else           d = RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/probe_addr_gen.sv
// Leading-edge probe address for a sprite moving one pixel in a direction; flags moves
// that would leave the screen and forces the address to 0 for them.
module probe_addr_gen
  import pacman_pkg::*;
#(
  parameter int WIDTH  = SCREEN_W,
  parameter int HEIGHT = SCREEN_H,
  parameter int SPRITE = SPRITE_PX,
  parameter int ADDR_W = MAP_ADDR_W
) (
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  dir_t              dir,
  input  logic              corner_b,
  output logic [ADDR_W-1:0] map_addr,
  output logic              out_of_bounds
);

  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] H_A = ADDR_W'(HEIGHT);
  localparam logic [ADDR_W-1:0] S_A = ADDR_W'(SPRITE);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] xw;
  logic [ADDR_W-1:0] yw;
  logic [ADDR_W-1:0] px;
  logic [ADDR_W-1:0] py;

  assign xw = ADDR_W'(x);
  assign yw = ADDR_W'(y);

  always_comb begin
    px            = xw;
    py            = yw;
    out_of_bounds = 1'b0;
    unique case (dir)
      UP: begin
        out_of_bounds = (yw == '0);
        py            = yw - ONE;
        px            = corner_b ? (xw + S_A - ONE) : xw;
      end
      DOWN: begin
        out_of_bounds = ((yw + S_A) >= H_A);
        py            = yw + S_A;
        px            = corner_b ? (xw + S_A - ONE) : xw;
      end
      LEFT: begin
        out_of_bounds = (xw == '0);
        px            = xw - ONE;
        py            = corner_b ? (yw + S_A - ONE) : yw;
      end
      RIGHT: begin
        out_of_bounds = ((xw + S_A) >= W_A);
        px            = xw + S_A;
        py            = corner_b ? (yw + S_A - ONE) : yw;
      end
      default: ;
    endcase
    // Full-width product: WIDTH*y must not be truncated below ADDR_W.
    map_addr = out_of_bounds ? '0 : (px + W_A * py);
  end

endmodule

// File: rtl/pacman_motion_controller.sv
// Per-frame Pacman movement scheduler: latches the requested turn, probes the walkability
// map at the sprite's leading edge, then steps one pixel, falls back to the heading, or stops.
module pacman_motion_controller
  import pacman_pkg::*;
#(
  parameter int WIDTH   = SCREEN_W,
  parameter int HEIGHT  = SCREEN_H,
  parameter int SPRITE  = SPRITE_PX,
  parameter int START_X = START_X_PX,
  parameter int START_Y = START_Y_PX,
  parameter int ADDR_W  = MAP_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              move_en,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  output logic [ADDR_W-1:0] map_addr,
  input  logic              map_wall,
  output logic [9:0]        pacman_x,
  output logic [8:0]        pacman_y,
  output logic [1:0]        cur_dir,
  output logic              moving,
  output logic              blocked,
  output logic              move_done,
  output mc_state_t         dbg_state,
  output logic [1:0]        dbg_want_dir,
  output logic              dbg_want_v,
  output logic              dbg_cur_v
);

  mc_state_t         state_q, state_d;
  dir_t              cand_q, cand_d;
  dir_t              want_dir_q, want_dir_d;
  logic              want_v_q, want_v_d;
  dir_t              cur_dir_q, cur_dir_d;
  logic              cur_v_q, cur_v_d;
  logic [9:0]        x_q, x_d;
  logic [8:0]        y_q, y_d;
  logic              wall_a_q, wall_a_d;
  logic              wall_b_q, wall_b_d;
  logic              oob_q, oob_d;
  logic              moving_q, moving_d;
  logic              blocked_q, blocked_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  dir_t              start_dir;
  logic              start_v;
  logic              fallback_ok;
  logic              cand_clear;
  dir_t              gen_dir;
  logic              gen_corner_b;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_oob;

  assign start_v     = want_v_q | cur_v_q;
  assign start_dir   = want_v_q ? want_dir_q : cur_dir_q;
  assign fallback_ok = want_v_q && (cand_q == want_dir_q) && cur_v_q && (cur_dir_q != want_dir_q);
  assign cand_clear  = !oob_q && !wall_a_q && !wall_b_q;

  // The registered address is computed one cycle ahead of the state that presents it.
  always_comb begin
    gen_dir      = cand_q;
    gen_corner_b = 1'b0;
    unique case (state_q)
      IDLE:    gen_dir = start_dir;
      PROBE_A: gen_corner_b = 1'b1;
      DECIDE:  gen_dir = cur_dir_q;
      default: ;
    endcase
  end

  probe_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .SPRITE (SPRITE),
    .ADDR_W (ADDR_W)
  ) u_probe (
    .x             (x_q),
    .y             (y_q),
    .dir           (gen_dir),
    .corner_b      (gen_corner_b),
    .map_addr      (gen_addr),
    .out_of_bounds (gen_oob)
  );

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    want_dir_d = want_dir_q;
    want_v_d   = want_v_q;
    cur_dir_d  = cur_dir_q;
    cur_v_d    = cur_v_q;
    x_d        = x_q;
    y_d        = y_q;
    wall_a_d   = wall_a_q;
    wall_b_d   = wall_b_q;
    oob_d      = oob_q;
    moving_d   = moving_q;
    blocked_d  = blocked_q;
    done_d     = 1'b0;
    addr_d     = '0;

    // Sticky turn request; only a new press replaces it.
    if (btn_up || btn_down || btn_left || btn_right) begin
      want_dir_d = btn_priority(btn_up, btn_down, btn_left);
      want_v_d   = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (frame_tick && move_en) begin
          if (start_v) begin
            cand_d  = start_dir;
            addr_d  = gen_addr;
            state_d = PROBE_A;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      PROBE_A: begin
        addr_d  = gen_addr;
        oob_d   = gen_oob;
        state_d = PROBE_B;
      end
      PROBE_B: begin
        wall_a_d = map_wall;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        wall_b_d = map_wall;
        state_d  = DECIDE;
      end
      DECIDE: begin
        if (cand_clear) begin
          done_d  = 1'b1;
          state_d = STEP;
        end else if (fallback_ok) begin
          cand_d  = cur_dir_q;
          addr_d  = gen_addr;
          state_d = PROBE_A;
        end else begin
          blocked_d = 1'b1;
          moving_d  = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      STEP: begin
        unique case (cand_q)
          UP:      y_d = y_q - 9'd1;
          DOWN:    y_d = y_q + 9'd1;
          LEFT:    x_d = x_q - 10'd1;
          RIGHT:   x_d = x_q + 10'd1;
          default: ;
        endcase
        cur_dir_d = cand_q;
        cur_v_d   = 1'b1;
        moving_d  = 1'b1;
        blocked_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cand_q     <= UP;
      want_dir_q <= UP;
      want_v_q   <= 1'b0;
      cur_dir_q  <= UP;
      cur_v_q    <= 1'b0;
      x_q        <= 10'(START_X);
      y_q        <= 9'(START_Y);
      wall_a_q   <= 1'b0;
      wall_b_q   <= 1'b0;
      oob_q      <= 1'b0;
      moving_q   <= 1'b0;
      blocked_q  <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      want_dir_q <= want_dir_d;
      want_v_q   <= want_v_d;
      cur_dir_q  <= cur_dir_d;
      cur_v_q    <= cur_v_d;
      x_q        <= x_d;
      y_q        <= y_d;
      wall_a_q   <= wall_a_d;
      wall_b_q   <= wall_b_d;
      oob_q      <= oob_d;
      moving_q   <= moving_d;
      blocked_q  <= blocked_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
    end
  end

  assign map_addr     = addr_q;
  assign pacman_x     = x_q;
  assign pacman_y     = y_q;
  assign cur_dir      = cur_dir_q;
  assign moving       = moving_q;
  assign blocked      = blocked_q;
  assign move_done    = done_q;
  assign dbg_state    = state_q;
  assign dbg_want_dir = want_dir_q;
  assign dbg_want_v   = want_v_q;
  assign dbg_cur_v    = cur_v_q;

endmodule

// File: tb/tb_pacman_motion_controller.sv
// Bench for pacman_motion_controller: directed scenarios plus randomized frames checked
// against a geometric model of the sprite, its heading and a row/column wall map.
module tb_pacman_motion_controller;
  import pacman_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic        move_en = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [19:0] map_addr;
  logic        map_wall;
  logic [9:0]  pacman_x;
  logic [8:0]  pacman_y;
  logic [1:0]  cur_dir;
  logic        moving, blocked, move_done;
  mc_state_t   dbg_state;
  logic [1:0]  dbg_want_dir;
  logic        dbg_want_v, dbg_cur_v;

  int pass_cnt = 0;
  int check_cnt = 0;

  // Model state
  int m_x, m_y, m_cur_dir, m_want_dir;
  bit m_cur_v, m_want_v, m_moving, m_blocked;
  int wall_row = -1;
  int wall_col = -1;

  pacman_motion_controller dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .move_en(move_en),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .map_addr(map_addr), .map_wall(map_wall), .pacman_x(pacman_x), .pacman_y(pacman_y),
    .cur_dir(cur_dir), .moving(moving), .blocked(blocked), .move_done(move_done),
    .dbg_state(dbg_state), .dbg_want_dir(dbg_want_dir), .dbg_want_v(dbg_want_v),
    .dbg_cur_v(dbg_cur_v)
  );

  always #5 clk = ~clk;

  function automatic bit is_wall(int px, int py);
    return (py == wall_row) || (px == wall_col);
  endfunction

  // Map RAM: read data appears the cycle after the address.
  initial begin : map_ram
    int prev;
    prev = 0;
    map_wall = 1'b0;
    forever begin
      @(negedge clk);
      map_wall = is_wall(prev % 640, prev / 640);
      prev = int'(map_addr);
    end
  end

  function automatic bit in_bounds(int d, int x, int y);
    case (d)
      0: return y > 0;
      1: return y + 22 < 480;
      2: return x > 0;
      default: return x + 22 < 640;
    endcase
  endfunction

  // Pixel just beyond the sprite's leading edge; corner b is the far end of that edge.
  function automatic void corner(input int d, input int x, input int y, input bit b,
                                 output int cx, output int cy);
    case (d)
      0: begin cx = b ? x + 21 : x; cy = y - 1; end
      1: begin cx = b ? x + 21 : x; cy = y + 22; end
      2: begin cx = x - 1; cy = b ? y + 21 : y; end
      default: begin cx = x + 22; cy = b ? y + 21 : y; end
    endcase
  endfunction

  function automatic int exp_addr(int d, int x, int y, bit b);
    int cx, cy;
    if (!in_bounds(d, x, y)) return 0;
    corner(d, x, y, b, cx, cy);
    return cx + 640 * cy;
  endfunction

  function automatic bit dir_clear(int d, int x, int y);
    int ax, ay, bx, by;
    if (!in_bounds(d, x, y)) return 1'b0;
    corner(d, x, y, 1'b0, ax, ay);
    corner(d, x, y, 1'b1, bx, by);
    return !is_wall(ax, ay) && !is_wall(bx, by);
  endfunction

  function automatic void model_take(int d);
    case (d)
      0: m_y = m_y - 1;
      1: m_y = m_y + 1;
      2: m_x = m_x - 1;
      default: m_x = m_x + 1;
    endcase
    m_cur_dir = d; m_cur_v = 1'b1; m_moving = 1'b1; m_blocked = 1'b0;
  endfunction

  function automatic void model_block();
    m_blocked = 1'b1; m_moving = 1'b0;
  endfunction

  // Applies one evaluated frame to the model; returns the cycle move_done is expected in.
  function automatic int model_frame();
    int cand;
    if (m_want_v) cand = m_want_dir;
    else if (m_cur_v) cand = m_cur_dir;
    else return 1;
    if (dir_clear(cand, m_x, m_y)) begin
      model_take(cand);
      return 5;
    end
    if (m_want_v && m_cur_v && m_cur_dir != m_want_dir) begin
      if (dir_clear(m_cur_dir, m_x, m_y)) model_take(m_cur_dir);
      else model_block();
      return 9;
    end
    model_block();
    return 5;
  endfunction

  function automatic void model_reset();
    m_x = 310; m_y = 230; m_cur_dir = 0; m_want_dir = 0;
    m_cur_v = 0; m_want_v = 0; m_moving = 0; m_blocked = 0;
  endfunction

  task automatic tick_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_buttons(input bit u, input bit d, input bit l, input bit r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    if (u) begin m_want_dir = 0; m_want_v = 1; end
    else if (d) begin m_want_dir = 1; m_want_v = 1; end
    else if (l) begin m_want_dir = 2; m_want_v = 1; end
    else if (r) begin m_want_dir = 3; m_want_v = 1; end
    tick_cycle();
  endtask

  task automatic run_frame(input string tag, input bit check_addr);
    int exp_done, got_done, ea, eb, ga, gb, cand;
    bit has;
    has = 1'b1; cand = 0;
    if (m_want_v) cand = m_want_dir;
    else if (m_cur_v) cand = m_cur_dir;
    else has = 1'b0;
    ea = has ? exp_addr(cand, m_x, m_y, 1'b0) : 0;
    eb = has ? exp_addr(cand, m_x, m_y, 1'b1) : 0;
    exp_done = model_frame();
    frame_tick = 1'b1;
    got_done = 0; ga = -1; gb = -1;
    for (int c = 1; c <= 20; c++) begin
      tick_cycle();
      if (c == 1) begin frame_tick = 1'b0; ga = int'(map_addr); end
      if (c == 2) gb = int'(map_addr);
      if (move_done && got_done == 0) got_done = c;
      if (got_done != 0 && c > got_done) break;
    end
    check_cnt++;
    if (got_done != exp_done)
      $display("FAIL %s done_cycle: got %0d expected %0d", tag, got_done, exp_done);
    else pass_cnt++;
    check_cnt++;
    if (pacman_x !== 10'(m_x) || pacman_y !== 9'(m_y))
      $display("FAIL %s position: got (%0d,%0d) expected (%0d,%0d)", tag, pacman_x, pacman_y, m_x, m_y);
    else pass_cnt++;
    check_cnt++;
    if (cur_dir !== 2'(m_cur_dir) || moving !== m_moving || blocked !== m_blocked)
      $display("FAIL %s heading: got dir=%0d mv=%0b blk=%0b expected dir=%0d mv=%0b blk=%0b",
               tag, cur_dir, moving, blocked, m_cur_dir, m_moving, m_blocked);
    else pass_cnt++;
    if (check_addr && has) begin
      check_cnt++;
      if (ga != ea || gb != eb)
        $display("FAIL %s probe_addr: got %0d/%0d expected %0d/%0d", tag, ga, gb, ea, eb);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    check_cnt++;
    if (pacman_x !== 10'd310 || pacman_y !== 9'd230 || moving !== 1'b0 || blocked !== 1'b0 ||
        move_done !== 1'b0 || map_addr !== 20'd0 || cur_dir !== 2'd0 || dbg_want_v !== 1'b0)
      $display("FAIL reset_values: x=%0d y=%0d mv=%0b blk=%0b done=%0b addr=%0d expected 310 230 0 0 0 0",
               pacman_x, pacman_y, moving, blocked, move_done, map_addr);
    else pass_cnt++;
    check_cnt++;
    if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d expected IDLE", dbg_state);
    else pass_cnt++;
    repeat (3) tick_cycle();
    reset = 1'b0;
    model_reset();
    tick_cycle();
  endtask

  task automatic test_open_field();
    wall_row = -1; wall_col = -1;
    set_buttons(0, 0, 0, 1);
    set_buttons(0, 0, 0, 0);
    run_frame("open_field", 1'b1);
    check_cnt++;
    if (pacman_x !== 10'd311 || cur_dir !== 2'd3)
      $display("FAIL open_field_literal: got x=%0d dir=%0d expected x=311 dir=3", pacman_x, cur_dir);
    else pass_cnt++;
  endtask

  task automatic test_queued_turn_blocked();
    wall_row = m_y - 1; wall_col = -1;
    set_buttons(1, 0, 0, 0);
    set_buttons(0, 0, 0, 0);
    run_frame("queued_turn", 1'b1);
    check_cnt++;
    if (dbg_want_dir !== 2'd0 || dbg_want_v !== 1'b1)
      $display("FAIL queued_turn_want: got %0d/%0b expected 0/1", dbg_want_dir, dbg_want_v);
    else pass_cnt++;
  endtask

  task automatic test_dead_end();
    wall_row = m_y - 1; wall_col = m_x + 22;
    run_frame("dead_end", 1'b1);
  endtask

  task automatic test_mid_reset();
    wall_row = -1; wall_col = -1;
    set_buttons(0, 0, 0, 1);
    set_buttons(0, 0, 0, 0);
    frame_tick = 1'b1;
    tick_cycle();
    frame_tick = 1'b0;
    repeat (3) tick_cycle();
    #2 reset = 1'b1;
    #1;
    check_cnt++;
    if (pacman_x !== 10'd310 || pacman_y !== 9'd230 || moving !== 1'b0 || blocked !== 1'b0 ||
        map_addr !== 20'd0 || move_done !== 1'b0 || dbg_cur_v !== 1'b0 || dbg_state !== IDLE)
      $display("FAIL mid_reset: x=%0d y=%0d mv=%0b blk=%0b addr=%0d done=%0b expected 310 230 0 0 0 0",
               pacman_x, pacman_y, moving, blocked, map_addr, move_done);
    else pass_cnt++;
    tick_cycle();
    reset = 1'b0;
    model_reset();
    repeat (8) tick_cycle();
    check_cnt++;
    if (pacman_x !== 10'd310 || move_done !== 1'b0)
      $display("FAIL mid_reset_discard: got x=%0d expected 310", pacman_x);
    else pass_cnt++;
  endtask

  task automatic test_move_en();
    int dones;
    set_buttons(0, 0, 1, 0);
    set_buttons(0, 0, 0, 0);
    move_en = 1'b0;
    frame_tick = 1'b1;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      tick_cycle();
      frame_tick = 1'b0;
      if (move_done) dones++;
    end
    move_en = 1'b1;
    check_cnt++;
    if (dones != 0 || pacman_x !== 10'(m_x) || pacman_y !== 9'(m_y))
      $display("FAIL move_en_low: got %0d done pulses x=%0d expected 0 pulses x=%0d", dones, pacman_x, m_x);
    else pass_cnt++;
  endtask

  task automatic test_busy_tick_priority();
    int dones;
    wall_row = -1; wall_col = -1;
    set_buttons(1, 0, 0, 1);
    check_cnt++;
    if (dbg_want_dir !== 2'd0 || dbg_want_v !== 1'b1)
      $display("FAIL priority: got want_dir=%0d expected 0", dbg_want_dir);
    else pass_cnt++;
    set_buttons(0, 0, 0, 0);
    void'(model_frame());
    dones = 0;
    frame_tick = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick_cycle();
      frame_tick = (c == 2);
      if (move_done) dones++;
    end
    check_cnt++;
    if (dones != 1 || pacman_y !== 9'(m_y) || pacman_x !== 10'(m_x))
      $display("FAIL busy_tick: got %0d pulses y=%0d expected 1 pulse y=%0d", dones, pacman_y, m_y);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: set_buttons(1, 0, 0, 0);
        1: set_buttons(0, 1, 0, 0);
        2: set_buttons(0, 0, 1, 0);
        3: set_buttons(0, 0, 0, 1);
        4: set_buttons(0, 0, 0, 0);
        default: set_buttons(0, $urandom_range(0, 1), 1, 1);
      endcase
      set_buttons(0, 0, 0, 0);
      wall_row = ($urandom_range(0, 2) == 0) ? -1 : m_y - 8 + $urandom_range(0, 38);
      wall_col = ($urandom_range(0, 2) == 0) ? -1 : m_x - 8 + $urandom_range(0, 38);
      run_frame("random", 1'b1);
    end
  endtask

  task automatic test_screen_edge();
    wall_row = -1; wall_col = -1;
    set_buttons(0, 0, 1, 0);
    set_buttons(0, 0, 0, 0);
    for (int i = 0; i < 700 && m_x > 0; i++) run_frame("walk_left", 1'b0);
    run_frame("left_edge", 1'b1);
    check_cnt++;
    if (pacman_x !== 10'd0 || blocked !== 1'b1)
      $display("FAIL left_edge_literal: got x=%0d blk=%0b expected 0 1", pacman_x, blocked);
    else pass_cnt++;
    set_buttons(0, 0, 0, 1);
    set_buttons(0, 0, 0, 0);
    for (int i = 0; i < 700 && m_x < 618; i++) run_frame("walk_right", 1'b0);
    run_frame("right_edge", 1'b1);
    check_cnt++;
    if (pacman_x !== 10'd618 || blocked !== 1'b1)
      $display("FAIL right_edge_literal: got x=%0d blk=%0b expected 618 1", pacman_x, blocked);
    else pass_cnt++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_open_field();
    test_queued_turn_blocked();
    test_dead_end();
    test_mid_reset();
    test_move_en();
    test_busy_tick_priority();
    test_random();
    test_screen_edge();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/pacman_motion_controller.md
# pacman_motion_controller

Per-frame movement scheduler for the Pacman sprite. Once per frame it takes the player's latched direction request, runs wall probes against the level walkability map through a shared single-port read interface, and then either steps the sprite one pixel or stops it. It owns the authoritative `pacman_x`/`pacman_y` that the VGA pixel mux uses for sprite placement, and it arbitrates between the queued turn and the current heading, Pacman-style.

## Interface
Parameters:
- `WIDTH`, 640: screen width, px.
- `HEIGHT`, 480: screen height, px.
- `SPRITE`, 22: sprite edge, px.
- `START_X`, 310: reset x.
- `START_Y`, 230: reset y.
- `ADDR_W`, 20: map address width, equal to $clog2(WIDTH*HEIGHT)+1.

Ports:
- `clk` in 1: 100 MHz system clock.
- `reset` in 1: asynchronous, active-high.
- `frame_tick` in 1: one-cycle pulse in the `clk` domain at frame end.
- `move_en` in 1: gameplay enabled; low means ticks are ignored.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: debounced, level buttons.
- `map_addr` out `ADDR_W`: probe address, x + WIDTH*y.
- `map_wall` in 1: walkability read data, 1 = wall. Valid the cycle after `map_addr` is presented.
- `pacman_x` out 10: sprite top-left x.
- `pacman_y` out 9: sprite top-left y.
- `cur_dir` out 2: heading, encoded 0 up, 1 down, 2 left, 3 right.
- `moving` out 1: `cur_dir` is valid and the last frame stepped.
- `blocked` out 1: last evaluation found no legal move.
- `move_done` out 1: one-cycle pulse when a frame evaluation finishes.

## Operation
Direction queue:
- `want_dir`/`want_v` are updated every cycle from the buttons. Priority when several are pressed: up > down > left > right.
- The request is sticky until another button is pressed. It is never cleared by a move.

FSM states: IDLE, PROBE_A, PROBE_B, CAPTURE, DECIDE, STEP.
- IDLE -> PROBE_A on `frame_tick & move_en`, with candidate = `want_dir` if `want_v`, else `cur_dir` if `cur_v`. If neither is valid, stay in IDLE and pulse `move_done`.
- PROBE_A: drive corner A address.
- PROBE_B: drive corner B address; register `map_wall` as wall_A.
- CAPTURE: register `map_wall` as wall_B.
- DECIDE, when the candidate is clear (both walls 0 and within bounds): go to STEP.
- DECIDE, when the candidate is blocked and candidate == `want_dir` and `cur_v` and `cur_dir != want_dir`: set candidate = `cur_dir` and return to PROBE_A (fallback).
- DECIDE, otherwise: set `blocked`=1, clear `moving`, pulse `move_done`, go to IDLE.
- STEP: move one pixel in the candidate direction. Set `cur_dir` = candidate, `cur_v`=1, `moving`=1, `blocked`=0. Pulse `move_done`, go to IDLE.

Probe corners (leading edge, x/y = current position):
- right: (x+SPRITE, y) and (x+SPRITE, y+SPRITE-1).
- left: (x-1, y) and (x-1, y+SPRITE-1).
- down: (x, y+SPRITE) and (x+SPRITE-1, y+SPRITE).
- up: (x, y-1) and (x+SPRITE-1, y-1).

Bounds rule:
- Right is blocked if x+SPRITE ≥ WIDTH. Left is blocked if x==0. Down is blocked if y+SPRITE ≥ HEIGHT. Up is blocked if y==0.
- For an out-of-bounds candidate the probes still run, but `map_addr` is forced to 0 and the wall data is ignored.

Arithmetic: address computed at 20 bits, with no truncation of WIDTH*y.

## Timing
Reset values:
- `pacman_x`=START_X, `pacman_y`=START_Y.
- `cur_dir`=0, `cur_v`=0, `want_v`=0.
- `moving`=0, `blocked`=0, `move_done`=0, `map_addr`=0.
- State = IDLE.

Latency from `frame_tick` (cycle 0):
- PROBE_A is cycle 1.
- A direct success updates the position at the end of cycle 5 (STEP); `move_done` is high in cycle 5.
- A fallback success lands in cycle 9.

Boundary conditions:
- A `frame_tick` arriving outside IDLE is dropped; there is no queuing.
- A button change mid-evaluation updates `want_dir` but does not alter the candidate in flight.
- `reset` mid-evaluation returns everything to the reset values immediately; an in-flight step is discarded.
- All outputs are registered.

## Structure
- Package `pacman_pkg` holds the `dir_t` enum (UP/DOWN/LEFT/RIGHT), the `mc_state_t` enum, and the localparams for screen size, SPRITE and ADDR_W. The VGA controller shares this package.
- Sub-module `probe_addr_gen` is purely combinational. Inputs: x, y, dir, corner select. Outputs: `map_addr` and an out_of_bounds flag.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle -> x=310, y=230, `moving`=0, `blocked`=0, `map_addr`=0 with no clock edge.
- **Open field:** press `btn_right`, all-zero map, pulse `frame_tick` -> probes at addr 332+640*230 and 332+640*251; x=311 with `move_done` in cycle 5; `cur_dir`=3.
- **Queued turn blocked:** heading right, `btn_up` pressed, wall at row 229 -> up is rejected and the fallback right succeeds; x+1, `cur_dir` stays 3, `move_done` in cycle 9, `want_dir` remains up.
- **Dead end:** walls on both the wanted and current leading edges -> x and y unchanged, `blocked`=1, `moving`=0.
- **Screen edge:** force x=0 with left requested -> blocked, probe address 0, x stays 0. Likewise right at x=618.
- **Busy tick plus priority:** a second tick in cycle 2 is ignored (exactly one step); `btn_up`+`btn_right` pressed together -> `want_dir`=up.
